// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack data-memory port
//
// Ports:
//   clk, rst (async, active-low)
//   mem_read_m, mem_write_m, funct3_m, alu_result_m, write_data_m : MEM-stage control/data
//   read_data_m  : extended load result, non-zero only in DONE
//   stall_m      : holds IF..MEM while an access is in flight
//   bus_err_m    : DONE pulse after an ack timeout
//   misalign_m   : DONE pulse for a trapped misaligned access
//   dmem_req/we/addr/be/wdata, dmem_ack, dmem_rdata : data-memory port
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// instead of silently clearing the offending low address bits.
module mem_access_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_m,
    input  logic             mem_write_m,
    input  logic [2:0]       funct3_m,
    input  logic [WIDTH-1:0] alu_result_m,
    input  logic [WIDTH-1:0] write_data_m,
    output logic [WIDTH-1:0] read_data_m,
    output logic             stall_m,
    output logic             bus_err_m,
    output logic             misalign_m,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] addr_q, wd_q, rd_q;
    logic [2:0]       f3_q;
    logic [3:0]       be_q;
    logic             we_q, err_q;
    logic [CW-1:0]    cnt;

    logic             access, word, half;
    logic [WIDTH-1:0] addr_n, wd_n, sh, ext;
    logic [3:0]       be_n;

    assign access = mem_read_m | mem_write_m;
    assign word   = funct3_m[1];
    assign half   = !funct3_m[1] && funct3_m[0];
    // Low bits that would misalign the access are dropped; with the trap
    // enabled such accesses never reach the bus, so this is harmless there.
    assign addr_n = {alu_result_m[WIDTH-1:2], alu_result_m[1] & !word, alu_result_m[0] & !word & !half};
    assign be_n   = word ? 4'b1111 : (half ? 4'b0011 : 4'b0001) << addr_n[1:0];
    assign wd_n   = !mem_write_m ? '0 :
                    word ? write_data_m :
                    half ? {2{write_data_m[15:0]}} : {4{write_data_m[7:0]}};

    // Selected lane shifted down to bit 0, then sign/zero-extended by funct3[2].
    assign sh  = dmem_rdata >> {addr_q[1:0], 3'b000};
    assign ext = f3_q[1] ? sh :
                 f3_q[0] ? {{(WIDTH-16){!f3_q[2] & sh[15]}}, sh[15:0]} :
                           {{(WIDTH-8){!f3_q[2] & sh[7]}}, sh[7:0]};

`ifdef MISALIGN_TRAP_EN
    logic mis, mis_q;
    assign mis        = (half & alu_result_m[0]) | (word & |alu_result_m[1:0]);
    assign misalign_m = (state == DONE) && mis_q;
`else
    assign misalign_m = 1'b0;
`endif

    // Reset is folded in so stall_m drops immediately on an asynchronous reset
    // even while the pipeline still presents a memory instruction.
    assign stall_m     = (state == IDLE) ? (rst && access) : (state == BUSY);
    assign dmem_req    = (state == BUSY);
    assign dmem_we     = dmem_req && we_q;
    assign dmem_addr   = dmem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign dmem_be     = dmem_req ? be_q : 4'b0000;
    assign dmem_wdata  = dmem_req ? wd_q : '0;
    assign read_data_m = (state == DONE) ? rd_q : '0;
    assign bus_err_m   = (state == DONE) && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
            f3_q   <= '0;
            be_q   <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (access) begin
                    addr_q <= addr_n;
                    wd_q   <= wd_n;
                    f3_q   <= funct3_m;
                    be_q   <= be_n;
                    we_q   <= mem_write_m;
                    rd_q   <= '0;
                    err_q  <= 1'b0;
                    cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
                    mis_q  <= mis;
                    state  <= mis ? DONE : BUSY;
`else
                    state  <= BUSY;
`endif
                end
                BUSY: if (dmem_ack) begin
                    rd_q  <= we_q ? '0 : ext;
                    state <= DONE;
                end else if (cnt == LAST) begin
                    err_q <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (directed load/store vectors)
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read_m = 1'b0, mem_write_m = 1'b0;
    logic [2:0]  funct3_m = 3'b000;
    logic [31:0] alu_result_m = '0, write_data_m = '0;
    logic [31:0] read_data_m, dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_m, bus_err_m, misalign_m, dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
        int          stall;
        int          req;
    } comp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    comp_t       comp_q[$];
    bus_t        bus_q[$];
    int          checks = 0, errors = 0;
    int          ack_wait = 0;
    logic [31:0] rdata_val = '0;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .read_data_m(read_data_m), .stall_m(stall_m), .bus_err_m(bus_err_m),
        .misalign_m(misalign_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_wait wait cycles (-1 = never) and checks bus fields.
    initial begin
        int   n = 0;
        bus_t cur;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                if (n == 0) begin
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_unexpected: got req addr %h expected no request", dmem_addr);
                    end else cur = bus_q.pop_front();
                end
                chk("bus_we", {31'b0, dmem_we}, {31'b0, cur.we});
                chk("bus_addr", dmem_addr, cur.addr);
                chk("bus_be", {28'b0, dmem_be}, {28'b0, cur.be});
                chk("bus_wdata", dmem_wdata, cur.wdata);
                dmem_ack   = (n == ack_wait);
                dmem_rdata = dmem_ack ? rdata_val : 32'h5A5A5A5A;
                n++;
            end else begin
                n          = 0;
                dmem_ack   = 1'b0;
                dmem_rdata = '0;
                chk("bus_idle", {31'b0, |{dmem_we, dmem_addr, dmem_be, dmem_wdata}}, 32'h0);
            end
        end
    end

    // Monitor: a memory instruction with stall_m low marks the DONE cycle.
    initial begin
        int    sc = 0, rc = 0;
        comp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sc = 0;
                rc = 0;
            end else begin
                if (stall_m) sc++;
                if (dmem_req) rc++;
                if ((mem_read_m | mem_write_m) && !stall_m) begin
                    if (comp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got completion expected none");
                    end else begin
                        e = comp_q.pop_front();
                        chk("read_data", read_data_m, e.rd);
                        chk("bus_err", {31'b0, bus_err_m}, {31'b0, e.err});
                        chk("misalign", {31'b0, misalign_m}, {31'b0, e.mis});
                        chk("stall_cycles", sc, e.stall);
                        chk("req_cycles", rc, e.req);
                    end
                    sc = 0;
                    rc = 0;
                end else begin
                    chk("idle_outputs", {read_data_m[31:2], bus_err_m | read_data_m[1], misalign_m | read_data_m[0]}, 32'h0);
                end
            end
        end
    end

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int aw, input logic [31:0] rdat,
                      input logic [31:0] e_rd, input logic e_err, input logic e_mis,
                      input int e_stall, input int e_req, input logic [3:0] e_be,
                      input logic [31:0] e_addr, input logic [31:0] e_wdata);
        comp_t c;
        bus_t  b;
        int    i;
        c = '{rd: e_rd, err: e_err, mis: e_mis, stall: e_stall, req: e_req};
        comp_q.push_back(c);
        if (e_req > 0) begin
            b = '{we: wr, addr: e_addr, be: e_be, wdata: e_wdata};
            bus_q.push_back(b);
        end
        ack_wait  = aw;
        rdata_val = rdat;
        @(posedge clk);
        #1;
        mem_read_m   = rd;
        mem_write_m  = wr;
        funct3_m     = f3;
        alu_result_m = a;
        write_data_m = wd;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (stall_m && i < 100);
        if (stall_m) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got stall after %0d cycles expected completion", i);
        end
        @(posedge clk);
        #1;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall_m}, 32'h0);
        chk("rst_read_data", read_data_m, 32'h0);
        chk("rst_bus", {31'b0, |{dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, bus_err_m, misalign_m}}, 32'h0);
        rst = 1'b1;

        //  rd wr f3      addr         wdata         aw  rdata          exp_rd        err mis st req be       addr         wdata
        op(1, 0, 3'b010, 32'h100, 32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0,  2, 1,  4'b1111, 32'h100, 32'h0);
        op(1, 0, 3'b000, 32'h103, 32'h0,        0,  32'h80FF0000, 32'hFFFFFF80, 0, 0,  2, 1,  4'b1000, 32'h100, 32'h0);
        op(1, 0, 3'b100, 32'h103, 32'h0,        0,  32'h80FF0000, 32'h00000080, 0, 0,  2, 1,  4'b1000, 32'h100, 32'h0);
        op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 3,  32'h0,        32'h0,        0, 0,  5, 4,  4'b1100, 32'h100, 32'hABCDABCD);
        op(0, 1, 3'b000, 32'h201, 32'h000000A5, 1,  32'h0,        32'h0,        0, 0,  3, 2,  4'b0010, 32'h200, 32'hA5A5A5A5);
        op(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 0,  32'h0,        32'h0,        0, 0,  2, 1,  4'b1111, 32'h104, 32'hCAFEF00D);
        op(1, 0, 3'b001, 32'h102, 32'h0,        0,  32'h80017FFF, 32'hFFFF8001, 0, 0,  2, 1,  4'b1100, 32'h100, 32'h0);
        op(1, 0, 3'b101, 32'h100, 32'h0,        0,  32'h80019ABC, 32'h00009ABC, 0, 0,  2, 1,  4'b0011, 32'h100, 32'h0);
        op(1, 0, 3'b010, 32'h200, 32'h0,        -1, 32'h0,        32'h0,        1, 0, 17, 16, 4'b1111, 32'h200, 32'h0);
`ifdef MISALIGN_TRAP_EN
        op(1, 0, 3'b010, 32'h101, 32'h0,        0,  32'h11223344, 32'h0,        0, 1,  1, 0,  4'b0000, 32'h0,   32'h0);
        op(1, 0, 3'b001, 32'h103, 32'h0,        0,  32'h80010000, 32'h0,        0, 1,  1, 0,  4'b0000, 32'h0,   32'h0);
`else
        op(1, 0, 3'b010, 32'h101, 32'h0,        0,  32'h11223344, 32'h11223344, 0, 0,  2, 1,  4'b1111, 32'h100, 32'h0);
        op(1, 0, 3'b001, 32'h103, 32'h0,        0,  32'h80010000, 32'hFFFF8001, 0, 0,  2, 1,  4'b1100, 32'h100, 32'h0);
`endif

        // Asynchronous reset in the middle of a never-acked load.
        begin
            bus_t b;
            b = '{we: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'h0};
            bus_q.push_back(b);
        end
        ack_wait = -1;
        @(posedge clk);
        #1;
        mem_read_m   = 1'b1;
        funct3_m     = 3'b010;
        alu_result_m = 32'h300;
        repeat (3) @(negedge clk);
        chk("busy_req", {31'b0, dmem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stall", {31'b0, stall_m}, 32'h0);
        chk("arst_req", {31'b0, dmem_req}, 32'h0);
        chk("arst_addr", dmem_addr, 32'h0);
        chk("arst_be_we", {27'b0, dmem_be, dmem_we}, 32'h0);
        chk("arst_other", {read_data_m[31:2], bus_err_m | read_data_m[1], misalign_m | read_data_m[0]}, 32'h0);
        mem_read_m = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("add_stall", {31'b0, stall_m}, 32'h0);
        chk("add_read_data", read_data_m, 32'h0);

        repeat (3) @(negedge clk);
        chk("comp_q_empty", comp_q.size(), 32'h0);
        chk("bus_q_empty", bus_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
